// File: rtl/shader_execute_param.sv
// shader_execute_param: per-pixel shader execution unit.
// Executes one 8-bit instruction per valid/ready handshake on a four-entry
// register file. MUL is an iterative shift-add multiply. A pixel commit
// latches the working colour onto rgb_o.
module shader_execute_param #(
  parameter int DATA_W   = 6,
  parameter int CH_W     = 2,
  parameter int NUM_REGS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [7:0]          instr_i,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  input  logic [DATA_W-1:0]   x_pos_i,
  input  logic [DATA_W-1:0]   y_pos_i,
  input  logic [DATA_W-1:0]   time_i,
  input  logic [DATA_W-1:0]   user_i,
  input  logic                pixel_end_i,
  output logic [3*CH_W-1:0]   rgb_o,
  output logic                rgb_valid_o,
  output logic                busy_o
);

  localparam int RGB_W  = 3 * CH_W;
  localparam int WIDE_W = (DATA_W > RGB_W) ? DATA_W : RGB_W;
  localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  // Quarter-wave sine entry: floor((2^DATA_W-1)*sin(pi*k/30)), using a
  // 16-bit fixed-point fraction of sin(pi*k/30) (k = 15 is exactly 1.0).
  function automatic logic [DATA_W-1:0] sine_entry(input logic [3:0] k);
    logic [16:0] frac;
    logic [63:0] prod;
    case (k)
      4'd0:    frac = 17'd0;
      4'd1:    frac = 17'd6850;
      4'd2:    frac = 17'd13625;
      4'd3:    frac = 17'd20251;
      4'd4:    frac = 17'd26655;
      4'd5:    frac = 17'd32768;
      4'd6:    frac = 17'd38521;
      4'd7:    frac = 17'd43852;
      4'd8:    frac = 17'd48702;
      4'd9:    frac = 17'd53019;
      4'd10:   frac = 17'd56755;
      4'd11:   frac = 17'd59870;
      4'd12:   frac = 17'd62328;
      4'd13:   frac = 17'd64103;
      4'd14:   frac = 17'd65176;
      4'd15:   frac = 17'd65536;
      default: frac = 17'd0;
    endcase
    prod = ((64'd1 << DATA_W) - 64'd1) * {47'd0, frac};
    return DATA_W'(prod >> 16);
  endfunction

  logic [DATA_W-1:0] regs_r  [NUM_REGS];
  logic [DATA_W-1:0] regs_nx [NUM_REGS];
  logic [RGB_W-1:0]  colour_r;
  logic [RGB_W-1:0]  colour_nx;
  logic [RGB_W-1:0]  rgb_r;
  logic              skip_r;
  logic              skip_instr_s;
  logic              skip_nx_s;
  logic              busy_r;
  logic              pending_r;
  logic              rgb_valid_r;
  logic              accept_s;
  logic              exec_s;
  logic              commit_s;
  logic              mul_start_s;
  logic              mul_last_s;
  logic [1:0]        op_a_s;
  logic [1:0]        op_b_s;
  logic [DATA_W-1:0] ra_s;
  logic [DATA_W-1:0] rb_s;
  logic [DATA_W-1:0] r0_s;
  logic [DATA_W-1:0] mul_acc_r;
  logic [DATA_W-1:0] mul_mcand_r;
  logic [DATA_W-1:0] mul_mplier_r;
  logic [DATA_W-1:0] mul_acc_nx_s;
  logic [1:0]        mul_dst_r;
  logic [CNT_W-1:0]  mul_cnt_r;
  logic [WIDE_W-1:0] wide_s;
  logic [3:0]        sine_idx_s;
  logic [DATA_W-1:0] sine_q [16];

  // The sine table is built from constants at elaboration.
  for (genvar k = 0; k < 16; k++) begin : g_sine
    assign sine_q[k] = sine_entry(4'(k));
  end

  assign op_a_s   = instr_i[1:0];
  assign op_b_s   = instr_i[3:2];
  assign ra_s     = regs_r[op_a_s];
  assign rb_s     = regs_r[op_b_s];
  assign r0_s     = regs_r[0];
  assign wide_s   = WIDE_W'(ra_s);
  assign accept_s = instr_valid_i && !busy_r;
  assign exec_s   = accept_s && !skip_r;

  // Odd quadrants read the quarter-wave table backwards.
  assign sine_idx_s = r0_s[DATA_W-2] ? (4'd15 - r0_s[DATA_W-3 -: 4])
                                     : r0_s[DATA_W-3 -: 4];

  assign mul_acc_nx_s = mul_acc_r + (mul_mplier_r[0] ? mul_mcand_r : {DATA_W{1'b0}});
  assign mul_last_s   = (mul_cnt_r == CNT_LAST);

  // A commit fires on pixel_end_i, or on a commit deferred by an earlier MUL.
  assign commit_s  = !busy_r && (pixel_end_i || pending_r);
  assign skip_nx_s = commit_s ? 1'b0 : skip_instr_s;

  // Instruction decode: next register file, working colour, skip and MUL start.
  always_comb begin
    regs_nx      = regs_r;
    colour_nx    = colour_r;
    skip_instr_s = skip_r;
    mul_start_s  = 1'b0;
    if (busy_r) begin
      if (mul_last_s) begin
        regs_nx[mul_dst_r] = mul_acc_nx_s;
      end else begin
        regs_nx = regs_r;
      end
    end else if (accept_s) begin
      if (!exec_s) begin
        skip_instr_s = 1'b0;
      end else begin
        case (instr_i[7:6])
          2'b00: begin
            case (instr_i[5:2])
              4'b0000: colour_nx = wide_s[RGB_W-1:0];
              4'b0001: colour_nx[3*CH_W-1 -: CH_W] = ra_s[CH_W-1:0];
              4'b0010: colour_nx[2*CH_W-1 -: CH_W] = ra_s[CH_W-1:0];
              4'b0011: colour_nx[CH_W-1:0] = ra_s[CH_W-1:0];
              4'b0100: regs_nx[op_a_s] = x_pos_i;
              4'b0101: regs_nx[op_a_s] = y_pos_i;
              4'b0110: regs_nx[op_a_s] = time_i;
              4'b0111: regs_nx[op_a_s] = user_i;
              4'b1000: skip_instr_s = !(ra_s == r0_s);
              4'b1001: skip_instr_s = !(ra_s != r0_s);
              4'b1010: skip_instr_s = !(ra_s >= r0_s);
              4'b1011: skip_instr_s = !(ra_s < r0_s);
              4'b1100: colour_nx = {3{ra_s[DATA_W-1 -: CH_W]}};
              4'b1101: mul_start_s = 1'b1;
              4'b1110: regs_nx[op_a_s] = {1'b0, ra_s[DATA_W-1:1]};
              4'b1111: regs_nx[op_a_s] = sine_q[sine_idx_s];
              default: regs_nx = regs_r;
            endcase
          end
          2'b01: begin
            case (instr_i[5:4])
              2'b00:   regs_nx[op_a_s] = ra_s & rb_s;
              2'b01:   regs_nx[op_a_s] = ra_s | rb_s;
              2'b10:   regs_nx[op_a_s] = ~rb_s;
              2'b11:   regs_nx[op_a_s] = ra_s ^ rb_s;
              default: regs_nx = regs_r;
            endcase
          end
          2'b10: begin
            // Logical shifts by DATA_W or more already produce zero.
            case (instr_i[5:4])
              2'b00:   regs_nx[op_a_s] = rb_s;
              2'b01:   regs_nx[op_a_s] = ra_s + rb_s;
              2'b10:   regs_nx[op_a_s] = ra_s << rb_s;
              2'b11:   regs_nx[op_a_s] = ra_s >> rb_s;
              default: regs_nx = regs_r;
            endcase
          end
          2'b11:   regs_nx[0] = DATA_W'(instr_i[5:0]);
          default: regs_nx = regs_r;
        endcase
      end
    end else begin
      skip_instr_s = skip_r;
    end
  end

  // Architectural state: register file, working colour and skip flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      colour_r <= {RGB_W{1'b0}};
      skip_r   <= 1'b0;
    end else begin
      regs_r   <= regs_nx;
      colour_r <= colour_nx;
      skip_r   <= skip_nx_s;
    end
  end

  // Shift-add multiplier: one partial product per busy cycle, DATA_W cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_r       <= 1'b0;
      mul_cnt_r    <= {CNT_W{1'b0}};
      mul_acc_r    <= {DATA_W{1'b0}};
      mul_mcand_r  <= {DATA_W{1'b0}};
      mul_mplier_r <= {DATA_W{1'b0}};
      mul_dst_r    <= 2'b00;
    end else if (mul_start_s) begin
      busy_r       <= 1'b1;
      mul_cnt_r    <= {CNT_W{1'b0}};
      mul_acc_r    <= {DATA_W{1'b0}};
      mul_mcand_r  <= ra_s;
      mul_mplier_r <= r0_s;
      mul_dst_r    <= op_a_s;
    end else if (busy_r) begin
      busy_r       <= !mul_last_s;
      mul_cnt_r    <= mul_cnt_r + 1'b1;
      mul_acc_r    <= mul_acc_nx_s;
      mul_mcand_r  <= {mul_mcand_r[DATA_W-2:0], 1'b0};
      mul_mplier_r <= {1'b0, mul_mplier_r[DATA_W-1:1]};
    end else begin
      busy_r       <= 1'b0;
    end
  end

  // Commit path: defer pixel_end_i while busy, latch colour and pulse valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_r   <= 1'b0;
      rgb_r       <= {RGB_W{1'b0}};
      rgb_valid_r <= 1'b0;
    end else begin
      rgb_valid_r <= commit_s;
      if (commit_s) begin
        rgb_r     <= colour_nx;
        pending_r <= 1'b0;
      end else if (pixel_end_i && busy_r) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  assign rgb_o         = rgb_r;
  assign rgb_valid_o   = rgb_valid_r;
  assign busy_o        = busy_r;
  assign instr_ready_o = !busy_r;

endmodule

// File: tb/tb_shader_execute_param.sv
// Self-checking bench for shader_execute_param: directed scenarios followed by
// random instruction streams, checked against a transaction-level model.
module tb_shader_execute_param;

  localparam int DW = 6;
  localparam int CW = 2;

  logic            clk = 1'b1;
  logic            rst;
  logic [7:0]      instr;
  logic            instr_valid;
  logic            instr_ready;
  logic [DW-1:0]   x_pos;
  logic [DW-1:0]   y_pos;
  logic [DW-1:0]   time_v;
  logic [DW-1:0]   user_v;
  logic            pixel_end;
  logic [3*CW-1:0] rgb;
  logic            rgb_valid;
  logic            busy;

  always #5 clk = ~clk;

  shader_execute_param #(.DATA_W(DW), .CH_W(CW), .NUM_REGS(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_i       (instr),
    .instr_valid_i (instr_valid),
    .instr_ready_o (instr_ready),
    .x_pos_i       (x_pos),
    .y_pos_i       (y_pos),
    .time_i        (time_v),
    .user_i        (user_v),
    .pixel_end_i   (pixel_end),
    .rgb_o         (rgb),
    .rgb_valid_o   (rgb_valid),
    .busy_o        (busy)
  );

  typedef struct {
    bit busy;
    bit valid;
  } cyc_exp_t;

  cyc_exp_t cyc_q[$];
  int       rgb_q[$];
  int       n_vec = 0;
  int       n_err = 0;

  // Reference model state
  int m_regs[4];
  int m_col;
  bit m_skip;
  bit m_pending;
  int m_busy_left;
  int m_mul_dst;
  int m_mul_val;
  int x_val, y_val, t_val, u_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_col = 0;
    m_skip = 1'b0;
    m_pending = 1'b0;
    m_busy_left = 0;
    m_mul_dst = 0;
    m_mul_val = 0;
  endfunction

  function automatic void model_exec(input int ins);
    int a, b, ra, rb, r0, q, i, k;
    a  = ins % 4;
    b  = (ins / 4) % 4;
    ra = m_regs[a];
    rb = m_regs[b];
    r0 = m_regs[0];
    case (ins / 64)
      0: begin
        case ((ins / 4) % 16)
          0:  m_col = ra % 64;
          1:  m_col = (ra % 4) * 16 + m_col % 16;
          2:  m_col = (m_col / 16) * 16 + (ra % 4) * 4 + m_col % 4;
          3:  m_col = (m_col / 4) * 4 + ra % 4;
          4:  m_regs[a] = x_val;
          5:  m_regs[a] = y_val;
          6:  m_regs[a] = t_val;
          7:  m_regs[a] = u_val;
          8:  m_skip = (ra != r0);
          9:  m_skip = (ra == r0);
          10: m_skip = (ra < r0);
          11: m_skip = (ra >= r0);
          12: m_col = (ra / 16) * 21;
          13: begin
            m_busy_left = DW;
            m_mul_dst   = a;
            m_mul_val   = (ra * r0) % 64;
          end
          14: m_regs[a] = ra / 2;
          default: begin
            q = r0 / 16;
            i = r0 % 16;
            k = (q % 2 == 1) ? 15 - i : i;
            m_regs[a] = $rtoi($floor(63.0 * $sin(3.141592653589793 * k / 30.0)));
          end
        endcase
      end
      1: begin
        case ((ins / 16) % 4)
          0:       m_regs[a] = ra & rb;
          1:       m_regs[a] = ra | rb;
          2:       m_regs[a] = 63 - rb;
          default: m_regs[a] = ra ^ rb;
        endcase
      end
      2: begin
        case ((ins / 16) % 4)
          0:       m_regs[a] = rb;
          1:       m_regs[a] = (ra + rb) % 64;
          2:       m_regs[a] = (rb >= DW) ? 0 : (ra * (1 << rb)) % 64;
          default: m_regs[a] = (rb >= DW) ? 0 : ra / (1 << rb);
        endcase
      end
      default: m_regs[0] = ins % 64;
    endcase
  endfunction

  // One clock of stimulus; the model predicts the state after the next edge.
  task automatic step(input bit r, input bit v, input logic [7:0] ins, input bit pe);
    bit exp_valid;
    @(negedge clk);
    rst         = r;
    instr_valid = v;
    instr       = ins;
    pixel_end   = pe;
    x_pos       = DW'(x_val);
    y_pos       = DW'(y_val);
    time_v      = DW'(t_val);
    user_v      = DW'(u_val);
    exp_valid   = 1'b0;
    if (r) begin
      model_reset();
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) m_regs[m_mul_dst] = m_mul_val;
      if (pe) m_pending = 1'b1;
    end else begin
      if (v) begin
        if (m_skip) m_skip = 1'b0;
        else model_exec(int'(ins));
      end
      if (pe || m_pending) begin
        rgb_q.push_back(m_col);
        m_pending = 1'b0;
        m_skip    = 1'b0;
        exp_valid = 1'b1;
      end
    end
    cyc_q.push_back('{busy: (m_busy_left > 0), valid: exp_valid});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_idle();
    while (m_busy_left > 0) idle();
  endtask

  task automatic issue(input logic [7:0] ins, input bit pe);
    wait_idle();
    step(1'b0, 1'b1, ins, pe);
  endtask

  // Issue an instruction together with a commit and pin the expected colour
  // to a constant worked out by hand.
  task automatic commit_const(input logic [7:0] ins, input int exp_rgb);
    issue(ins, 1'b1);
    if (rgb_q.size() > 0) rgb_q[rgb_q.size() - 1] = exp_rgb;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: per-cycle handshake/strobe checks and rgb scoreboard pops.
  always begin
    cyc_exp_t e;
    int       r;
    @(posedge clk);
    #1;
    if (cyc_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL cycle_queue_empty: got 0 entries expected 1 at %0t", $time);
    end else begin
      e = cyc_q.pop_front();
      check("busy_o", 32'(busy), 32'(e.busy));
      check("instr_ready_o", 32'(instr_ready), 32'(!e.busy));
      check("rgb_valid_o", 32'(rgb_valid), 32'(e.valid));
    end
    if (rgb_valid === 1'b1) begin
      if (rgb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_commit: got rgb %0d expected no commit at %0t", rgb, $time);
      end else begin
        r = rgb_q.pop_front();
        check("rgb_o", 32'(rgb), 32'(r));
      end
    end
  end

  initial begin
    x_val = 0; y_val = 0; t_val = 0; u_val = 0;
    model_reset();

    // Reset state, then commit the cleared colour.
    do_reset();
    do_reset();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    rgb_q[rgb_q.size() - 1] = 0;
    idle();

    // MUL 5*5 and 9*9 (mod 64).
    issue(8'hC5, 1'b0); issue(8'h81, 1'b0); issue(8'h35, 1'b0);
    commit_const(8'h01, 25);
    issue(8'hC9, 1'b0); issue(8'h81, 1'b0); issue(8'h35, 1'b0);
    commit_const(8'h01, 17);

    // Skip: IF== fails, SETR discarded, SETG executes.
    do_reset();
    x_val = 4;
    issue(8'hC3, 1'b0); issue(8'h11, 1'b0); issue(8'h21, 1'b0);
    issue(8'h05, 1'b0);
    commit_const(8'h09, 0);
    x_val = 0;

    // SINE quadrants.
    issue(8'hC5, 1'b0); issue(8'h3D, 1'b0); commit_const(8'h01, 31);
    issue(8'hD0, 1'b0); issue(8'h3D, 1'b0); commit_const(8'h01, 63);
    issue(8'hE0, 1'b0); issue(8'h3D, 1'b0); commit_const(8'h01, 0);
    issue(8'hFF, 1'b0); issue(8'h3D, 1'b0); commit_const(8'h01, 0);

    // SHL by DATA_W, HALF, SETGRAY.
    issue(8'hC1, 1'b0); issue(8'h81, 1'b0); issue(8'hC6, 1'b0); issue(8'hA1, 1'b0);
    commit_const(8'h01, 0);
    issue(8'hEA, 1'b0); issue(8'h81, 1'b0); issue(8'h39, 1'b0);
    commit_const(8'h01, 21);
    issue(8'hEA, 1'b0); issue(8'h81, 1'b0);
    commit_const(8'h31, 42);

    // Commit requested on the 2nd busy cycle of a MUL.
    do_reset();
    issue(8'hD2, 1'b0); issue(8'h00, 1'b0); issue(8'h35, 1'b0);
    idle();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    wait_idle();
    idle(); idle(); idle();

    // Reset on the 3rd busy cycle drops the MUL and the pending commit.
    do_reset();
    issue(8'hC5, 1'b0); issue(8'h81, 1'b0); issue(8'h35, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle();
    do_reset();
    idle(); idle(); idle();
    for (int i = 0; i < 4; i++) commit_const(8'(i), 0);

    // Random instruction streams.
    for (int n = 0; n < 3000; n++) begin
      x_val = int'($urandom_range(0, 63));
      y_val = int'($urandom_range(0, 63));
      t_val = int'($urandom_range(0, 63));
      u_val = int'($urandom_range(0, 63));
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 9) < 7,
           8'($urandom_range(0, 255)),
           $urandom_range(0, 5) == 0);
    end
    wait_idle();
    idle(); idle(); idle();

    @(posedge clk);
    #2;
    check("rgb_queue_drained", 32'(rgb_q.size()), 32'd0);
    check("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
